// File: rtl/adder_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_pkg
// Description : Shared constants and types for the adder-sharing controller.
//               Flag encodings returned with each response, the unsigned
//               mode encoding, and the default response-FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_share_pkg;

    localparam logic [3:0] FLAG_NONE   = 4'b0000;
    localparam logic [3:0] FLAG_UCARRY = 4'b0001;
    localparam logic [3:0] FLAG_SOVF   = 4'b0010;

    localparam logic [1:0] MODE_UNSIGNED = 2'b00;

    // Default entry geometry (NUM_REQ=4, W=30)
    localparam int RSP_ID_W  = 2;
    localparam int RSP_SUM_W = 30;

    typedef struct packed {
        logic [RSP_ID_W-1:0]  id;
        logic [RSP_SUM_W-1:0] sum;
        logic [3:0]           flags;
    } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/adder_share_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_rsp_fifo
// Description : Synchronous FIFO of response entries. Head is read straight
//               from storage (no write-to-read bypass), so an entry becomes
//               visible the cycle after it is pushed.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               push, push_data- write strobe / entry (ignored when full)
//               pop            - read strobe (ignored when empty)
//               head           - oldest entry
//               count/full/empty - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_rsp_fifo
    import adder_share_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = rsp_entry_t,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage carries no reset; contents are only observed when count > 0.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_ctrl
// Description : Shares one 1-cycle-latency adder between NUM_REQ requesters.
//               Round-robin arbitration with credit-based issue, result
//               capture into a response FIFO, valid/ready response channel.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               req_valid/ready/mode/a/b - per-requester request channels
//               add_mode/a/b, add_sum/flags - adder operand/result interface
//               rsp_valid/ready/id/sum/flags - response channel
//               stat_ovf_cnt, stat_busy_cnt - only with ADDER_SHARE_STATS_EN
// Options     : define ADDER_SHARE_STATS_EN to add saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int W          = 30,
    parameter int FIFO_DEPTH = 3,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_mode,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    output logic [1:0]           add_mode,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_sum,
    input  logic [3:0]           add_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic [3:0]           rsp_flags
`ifdef ADDER_SHARE_STATS_EN
    ,
    output logic [15:0]          stat_ovf_cnt,
    output logic [15:0]          stat_busy_cnt
`endif
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    sum;
        logic [3:0]      flags;
    } entry_t;

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_inflight;
    logic [ID_W-1:0]    r_inflight_id;

    entry_t             w_push_data;
    entry_t             w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W:0]   w_used;
    logic               w_issue_ok;
    logic               w_found;
    logic [ID_W-1:0]    w_gidx;
    logic [ID_W:0]      w_scan;
    logic               w_accept;
    logic               w_pop;

    // Credit: buffered + in-flight results must leave room for one more.
    // Only registered occupancy is used, so a same-cycle pop grants nothing.
    assign w_used     = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue_ok = ~w_full && (w_used < (c_CNT_W + 1)'(FIFO_DEPTH));

    // Round-robin search starting at r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_scan >= (ID_W + 1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W + 1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_accept = w_found & w_issue_ok & ~reset;

    // Operands are forced to zero whenever nothing is being issued.
    always_comb begin
        req_ready = '0;
        add_mode  = '0;
        add_a     = '0;
        add_b     = '0;
        if (w_accept) begin
            req_ready[w_gidx] = 1'b1;
            add_mode          = req_mode[w_gidx*2 +: 2];
            add_a             = req_a[w_gidx*W +: W];
            add_b             = req_b[w_gidx*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_inflight    <= 1'b0;
            r_inflight_id <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_inflight_id <= w_gidx;
                r_rr_ptr      <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    assign w_push_data = '{id: r_inflight_id, sum: add_sum, flags: add_flags};
    assign w_pop       = rsp_valid & rsp_ready;

    adder_share_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t),
        .CNT_W (c_CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Payload is gated so uninitialised storage never reaches the outputs.
    assign rsp_valid = ~w_empty & ~reset;
    assign rsp_id    = rsp_valid ? w_head.id    : '0;
    assign rsp_sum   = rsp_valid ? w_head.sum   : '0;
    assign rsp_flags = rsp_valid ? w_head.flags : '0;

`ifdef ADDER_SHARE_STATS_EN
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_busy_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_cnt  <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (r_inflight && (add_flags != FLAG_NONE) && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
            if ((|req_valid) && !w_accept && (r_busy_cnt != 16'hFFFF)) begin
                r_busy_cnt <= r_busy_cnt + 16'd1;
            end
        end
    end

    assign stat_ovf_cnt  = r_ovf_cnt;
    assign stat_busy_cnt = r_busy_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_ctrl
// Description : Self-checking bench for adder_share_ctrl. Includes a
//               behavioural 1-cycle adder, an expected-response queue fed on
//               each accepted request, and a negedge monitor that checks
//               grants, operands, response timing and contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int W       = 30;
    localparam int DEPTH   = 3;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_mode;
    logic [W*NUM_REQ-1:0] req_a;
    logic [W*NUM_REQ-1:0] req_b;
    logic [1:0]           add_mode;
    logic [W-1:0]         add_a;
    logic [W-1:0]         add_b;
    logic [W-1:0]         add_sum;
    logic [3:0]           add_flags;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_sum;
    logic [3:0]           rsp_flags;
`ifdef ADDER_SHARE_STATS_EN
    logic [15:0]          stat_ovf_cnt;
    logic [15:0]          stat_busy_cnt;
`endif

    adder_share_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .W          (W),
        .FIFO_DEPTH (DEPTH),
        .ID_W       (ID_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_mode  (add_mode),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_flags (add_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_flags (rsp_flags)
`ifdef ADDER_SHARE_STATS_EN
        ,
        .stat_ovf_cnt  (stat_ovf_cnt),
        .stat_busy_cnt (stat_busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural adder: registered sum, carry / overflow from bit logic.
    always @(posedge clk) begin
        logic [W:0] s;
        if (reset) begin
            add_sum   <= '0;
            add_flags <= 4'b0000;
        end else begin
            s = {1'b0, add_a} + {1'b0, add_b};
            add_sum <= s[W-1:0];
            if (add_mode == 2'b00)
                add_flags <= s[W] ? 4'b0001 : 4'b0000;
            else
                add_flags <= ((add_a[W-1] == add_b[W-1]) && (s[W-1] != add_a[W-1])) ? 4'b0010 : 4'b0000;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic void ref_add(input logic [1:0] mode, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] sum,
                                    output logic [3:0] flags);
        longint ua, ub, us, sa, sb, ss;
        ua = longint'(a);
        ub = longint'(b);
        us = ua + ub;
        sum = us[W-1:0];
        if (mode == 2'b00) begin
            flags = (us >= (longint'(1) << W)) ? 4'b0001 : 4'b0000;
        end else begin
            sa = a[W-1] ? ua - (longint'(1) << W) : ua;
            sb = b[W-1] ? ub - (longint'(1) << W) : ub;
            ss = sa + sb;
            flags = (ss > ((longint'(1) << (W-1)) - 1) || ss < -(longint'(1) << (W-1))) ? 4'b0010 : 4'b0000;
        end
    endfunction

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        logic [3:0]   flags;
        int           cyc;
    } exp_t;

    exp_t               q[$];
    int                 cyc       = 0;
    int                 outst     = 0;
    int                 rr        = 0;
    int                 acc_total = 0;
    int                 ovf_m     = 0;
    int                 busy_m    = 0;
    logic [NUM_REQ-1:0] acc_vec   = '0;

    // Monitor: model arbitration/credit, push expectations, pop and compare.
    always @(negedge clk) begin
        int                 g, j, pops;
        bit                 found;
        logic [NUM_REQ-1:0] exp_ready;
        exp_t               e, h;
        bit                 exp_rv;
        cyc++;
        if (reset) begin
            chk("ready_in_reset", req_ready, 0);
            chk("rsp_valid_in_reset", rsp_valid, 0);
            chk("add_in_reset", {add_mode, add_a, add_b}, 0);
            q.delete();
            outst   = 0;
            rr      = 0;
            acc_vec = '0;
            ovf_m   = 0;
            busy_m  = 0;
        end else begin
            found = 0;
            g     = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (rr + k) % NUM_REQ;
                if (!found && req_valid[j]) begin
                    found = 1;
                    g     = j;
                end
            end
            exp_ready = '0;
            if (found && outst < DEPTH) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);

            // rsp_valid expected once the oldest op is 2 cycles past accept
            exp_rv = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            chk("rsp_valid", rsp_valid, exp_rv);

            acc_vec = req_valid & req_ready;
            if (|acc_vec) begin
                e.id  = g;
                e.cyc = cyc;
                ref_add(req_mode[g*2 +: 2], req_a[g*W +: W], req_b[g*W +: W], e.sum, e.flags);
                chk("add_operands", {add_mode, add_a, add_b},
                    {req_mode[g*2 +: 2], req_a[g*W +: W], req_b[g*W +: W]});
                q.push_back(e);
                rr = (g + 1) % NUM_REQ;
                acc_total++;
                if (e.flags != 4'b0000) ovf_m++;
            end else begin
                chk("add_idle_zero", {add_mode, add_a, add_b}, 0);
                if (|req_valid) busy_m++;
            end

            pops = 0;
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    h = q.pop_front();
                    chk("rsp_id", rsp_id, h.id);
                    chk("rsp_sum", rsp_sum, h.sum);
                    chk("rsp_flags", rsp_flags, h.flags);
                    pops = 1;
                end
            end
            outst = outst + ((|acc_vec) ? 1 : 0) - pops;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_payload(input int i);
        int sel;
        sel = $urandom_range(0, 3);
        req_mode[i*2 +: 2] = 2'($urandom_range(0, 3));
        case (sel)
            0: req_a[i*W +: W] = {2'b00, 28'hFFFFFFF} + W'($urandom_range(0, 3));
            1: req_a[i*W +: W] = {2'b11, 28'hFFFFFFF};
            default: req_a[i*W +: W] = W'($urandom);
        endcase
        req_b[i*W +: W] = (sel == 3) ? W'($urandom_range(0, 2)) : W'($urandom);
    endtask

    // Requesters only change payload/valid when idle or just accepted.
    task automatic drive(input logic [NUM_REQ-1:0] want, input bit rnd);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || acc_vec[i]) begin
                req_valid[i] = rnd ? 1'($urandom_range(0, 1)) : want[i];
                new_payload(i);
            end
        end
    endtask

    task automatic issue_one(input int idx, input logic [1:0] mode, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] xs, input logic [3:0] xf);
        bit got;
        req_mode[idx*2 +: 2] = mode;
        req_a[idx*W +: W]    = a;
        req_b[idx*W +: W]    = b;
        req_valid            = '0;
        req_valid[idx]       = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1;
        end
        chk("single_accept", got, 1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_lat1_valid", rsp_valid, 0);
        @(negedge clk);
        chk("single_lat2_valid", rsp_valid, 1);
        chk("single_id", rsp_id, idx);
        chk("single_sum", rsp_sum, xs);
        chk("single_flags", rsp_flags, xf);
        step();
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int base;
        bit got;
        reset     = 1'b1;
        req_valid = '0;
        req_mode  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        step();

        issue_one(2, 2'b00, 30'h3FFFFFFF, 30'd1, 30'h0, 4'b0001);
        issue_one(0, 2'b01, 30'h1FFFFFFF, 30'd1, 30'h20000000, 4'b0010);
        idle(3);

        // Round robin with all requesters active: one accept every cycle
        drive('1, 0);
        step();
        base = acc_total;
        repeat (8) begin
            drive('1, 0);
            step();
        end
        chk("rr_no_gap", acc_total - base, 8);
        idle(4);

        // Backpressure: exactly DEPTH accepts, then stall
        rsp_ready = 1'b0;
        base = acc_total;
        repeat (8) begin
            drive('1, 0);
            step();
        end
        chk("bp_accepts", acc_total - base, DEPTH);
        chk("bp_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        base = acc_total;
        repeat (8) begin
            drive('1, 0);
            step();
        end
        chk("bp_resume", (acc_total - base) > 0, 1);
        idle(4);

        // Reset with results buffered and one in flight
        rsp_ready = 1'b0;
        base = acc_total;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            drive('1, 0);
            @(negedge clk);
            if (acc_total - base >= DEPTH) got = 1;
            @(posedge clk);
            #1;
        end
        chk("rst_fill", got, 1);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        idle(5);
        req_valid = '1;
        @(negedge clk);
        chk("rst_rr_zero", req_ready, 4'b0001);
        step();
        idle(4);

        // Randomised traffic
        repeat (3000) begin
            drive('0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) step();
        chk("drain_empty", q.size(), 0);
        step();
`ifdef ADDER_SHARE_STATS_EN
        chk("stat_ovf", stat_ovf_cnt, ovf_m);
        chk("stat_busy", stat_busy_cnt, busy_m);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
